uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   Transmit stage feeding the UART top level: takes one parallel byte per valid/ready
//   handshake and drives it on the serial TX line as one 8N1/8E1/8O1 frame.
//   Bit timing comes from an internal baud counter derived from the 125 MHz sysclk.
//   o_busy drives the transmitter-status RGB LED (led5) in the top level.
// PARAMETERS
//   CLK_FREQ_HZ  125_000_000  system clock frequency
//   BAUD_RATE    115_200      line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer divide, 1085 default)
//   PARITY_MODE  0            0 = none, 1 = even, 2 = odd
//   STOP_BITS    1            1 or 2
// PORTS
//   sysclk    in   1  system clock; all logic on rising edge
//   rst       in   1  synchronous, active-high reset
//   i_data    in   8  byte to send, LSB transmitted first
//   i_valid   in   1  i_data is valid this cycle
//   o_ready   out  1  block can accept a byte this cycle
//   o_tx      out  1  serial line, idle high
//   o_busy    out  1  frame in progress (any state other than IDLE)
//   o_done    out  1  one-cycle pulse: frame finished
// BEHAVIOUR
//   Reset: o_tx=1, o_ready=1, o_busy=0, o_done=0, state=IDLE, baud counter=0, bit index=0.
//   Only one clock and one reset; reset takes effect on the next sysclk edge, whatever the state.
//   Handshake: a byte is accepted on the edge where i_valid && o_ready.
//     On that edge i_data is latched into the shift register.
//     i_data may change after that edge without any effect.
//     o_ready=1 only in IDLE; i_valid while o_ready=0 is ignored (not queued).
//   FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     IDLE: o_tx=1; on accept -> START.
//     START: o_tx=0.
//     DATA: o_tx=shift[0]; shift right at each bit boundary; 8 bits, bit index 0..7.
//     PARITY: only if PARITY_MODE!=0. Even: ^data. Odd: ~^data, over the latched byte.
//     STOP: o_tx=1 for STOP_BITS bit periods.
//   Bit timing: every bit (start/data/parity/stop) is held exactly CLKS_PER_BIT cycles.
//     Baud counter counts 0..CLKS_PER_BIT-1 and resets to 0 on every state/bit transition.
//   Latency:
//     o_tx falls on the first edge after accept (accept at edge N => o_tx=0 after edge N+1).
//     Frame length = (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P = (PARITY_MODE!=0).
//   Completion: on the edge ending the last stop bit, FSM -> IDLE.
//     Same edge: o_done=1 for exactly one cycle, o_ready=1, o_busy=0.
//     o_done clears on the following edge.
//   Back-to-back: with i_valid held high, the next byte is accepted in the first IDLE cycle.
//     Minimum inter-frame idle is therefore 1 cycle (tx high).
//   Reset mid-frame: frame aborts.
//     o_tx=1 and o_ready=1 after the reset edge; no o_done is produced for the aborted byte.
//   Widths: baud counter is $clog2(CLKS_PER_BIT) bits, bit index 3 bits; no counter wraps except at the terminal count.
//   Illegal params: CLKS_PER_BIT<2, STOP_BITS not in {1,2}, or PARITY_MODE>2 => $error at elaboration.
// TESTING  (bench uses CLK_FREQ_HZ=400, BAUD_RATE=100 => CLKS_PER_BIT=4, sysclk period 8 ns)
//   1. Reset, hold 5 cycles
//      -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout.
//   2. Send 0xA5, PARITY_MODE=0, STOP_BITS=1; sample o_tx mid-bit (cycle 2 of each 4)
//      -> 0,1,0,1,0,0,1,0,1,1.
//      o_done pulses once, 40 cycles after the first o_tx=0 cycle.
//   3. PARITY_MODE=1, send 0x07 -> parity bit 1; PARITY_MODE=2, send 0x07 -> parity bit 0.
//      Frame is 44 cycles in both cases.
//   4. i_valid held high with 0x3C then 0xC3
//      -> exactly one tx=1 idle cycle between frames.
//      Both bytes decode correctly; 2 o_done pulses.
//   5. Pulse i_valid with 0xFF during DATA of a frame carrying 0x00
//      -> 0xFF ignored; only 0x00 is sent; o_ready=0 during the pulse.
//   6. Assert rst during data bit 3
//      -> o_tx=1 and o_ready=1 next cycle, no o_done.
//      A following 0x55 transmits correctly.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide valid/ready in, one asynchronous serial frame out.
// Frame layout is start bit, eight data bits LSB first, optional parity, then one
// or two stop bits. Bit timing comes from a baud counter clocked by sysclk.
//
// The line output is registered from the state the FSM held during the previous
// cycle. That is why o_tx falls one edge after the accept edge, and why the last
// stop bit is still on the line in the cycle where o_done pulses. It also keeps
// exactly one idle-high cycle between back-to-back frames.
`timescale 1ns/1ps

module uart_tx_serializer #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  // A bad parameter set would give a wrong baud rate or a broken frame format.
  // Such a set is stopped at elaboration so that it never reaches the board.
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_serializer: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic             w_bit_end;

  assign w_bit_end = (r_baud_cnt == CNT_LAST);

  // This is the frame sequencer.
  //
  // Every non-idle state holds its bit for CLKS_PER_BIT cycles, counted by the
  // baud counter. The counter returns to zero at every bit boundary.
  //
  // The same bit index counts the data bits and also the stop bits. It is always
  // cleared before it is reused.
  //
  // Parity is computed from i_data at the accept edge. The shift register is
  // destroyed during the data phase, so the parity cannot be taken from it later.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          if (i_valid && r_ready) begin
            r_shift  <= i_data;
            r_parity <= (PARITY_MODE == 2) ? ~^i_data : ^i_data;
            r_state  <= S_START;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              r_state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          r_tx <= r_parity;
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == STOP_LAST) begin
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          r_tx       <= 1'b1;
          r_ready    <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_tx    = r_tx;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Three instances share one clock, one reset and one
// data bus: no parity, even parity and odd parity. Each instance has its own valid.
// A line monitor decodes each frame at mid-bit and measures the frame length up to
// the o_done cycle. Each decoded frame is checked against a scoreboard entry that
// was queued when the byte was driven.
`timescale 1ns/1ps

module tb_uart_tx_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] dIn;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] done;

  int total = 0;
  int bad   = 0;

  // The clock period is 8 ns. With 400 Hz / 100 baud each bit lasts 4 clocks.
  always #4 clock = ~clock;

  uart_tx_serializer #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .PARITY_MODE(0), .STOP_BITS(1)) dutNone (
    .sysclk(clock), .rst(reset), .i_data(dIn), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));

  uart_tx_serializer #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .PARITY_MODE(1), .STOP_BITS(1)) dutEven (
    .sysclk(clock), .rst(reset), .i_data(dIn), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));

  uart_tx_serializer #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .PARITY_MODE(2), .STOP_BITS(1)) dutOdd (
    .sysclk(clock), .rst(reset), .i_data(dIn), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));

  typedef struct {
    int          dut;
    logic [15:0] bits;
    int          len;
  } expect_t;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       expPar;
    int         expLen;
  } vec_t;

  expect_t     expQ[$];
  bit          monActive[3];
  int          monIdx[3];
  logic [15:0] monBits[3];
  int          gapCnt[3];
  int          lastGap[3];
  int          doneCnt[3];
  int          framesDone = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Build the expected line bits: the start bit comes first, then the data LSB first, then parity and stop bits.
  function automatic expect_t makeExpect(input int k, input logic [7:0] d, input logic hasPar,
                                         input logic par, input int len);
    expect_t e;
    e.dut  = k;
    e.bits = '0;
    e.bits[8:1] = d;
    if (hasPar) begin
      e.bits[9]  = par;
      e.bits[10] = 1'b1;
    end else begin
      e.bits[9]  = 1'b1;
    end
    e.len = len;
    return e;
  endfunction

  task automatic finishFrame(input int k, input logic [15:0] bits, input int len);
    expect_t e;
    checkOutput($sformatf("dut%0d frame was expected", k), (expQ.size() > 0), 1);
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    checkOutput("frame owner", k, e.dut);
    checkOutput($sformatf("dut%0d frame bits", k), bits, e.bits);
    checkOutput($sformatf("dut%0d frame length", k), len, e.len);
  endtask

  // This is the line monitor. A frame starts on the first low sample and is sampled at cycle 2 of each bit.
  // It closes on the o_done cycle, or after 64 cycles if o_done never arrives.
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        if (done[k] === 1'b1) doneCnt[k]++;
        if (reset === 1'b1) begin
          monActive[k] = 1'b0;
          gapCnt[k]    = 0;
        end else begin
          if (!monActive[k]) begin
            if (tx[k] === 1'b0) begin
              monActive[k] = 1'b1;
              monIdx[k]    = 0;
              monBits[k]   = '0;
              lastGap[k]   = gapCnt[k];
              gapCnt[k]    = 0;
            end else begin
              gapCnt[k]++;
            end
          end
          if (monActive[k]) begin
            if (monIdx[k] % 4 == 2) monBits[k][monIdx[k] / 4] = tx[k];
            if (done[k] === 1'b1 || monIdx[k] >= 63) begin
              monActive[k] = 1'b0;
              framesDone++;
              finishFrame(k, monBits[k], monIdx[k] + 1);
            end else begin
              monIdx[k]++;
            end
          end
        end
      end
    end
  end

  task automatic waitReady(input int k);
    int budget = 0;
    while (rdy[k] !== 1'b1 && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    checkOutput($sformatf("dut%0d ready before send", k), rdy[k], 1);
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] d, input logic hasPar,
                               input logic par, input int len, input bit push);
    waitReady(k);
    @(posedge clock); #1;
    dIn    = d;
    vld[k] = 1'b1;
    if (push) expQ.push_back(makeExpect(k, d, hasPar, par, len));
    @(posedge clock); #1;
    vld[k] = 1'b0;
  endtask

  task automatic waitFrames(input int target);
    int budget = 0;
    while (framesDone < target && budget < 300) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("frame completed in time", (framesDone >= target), 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int   target = 0;
    int   base;
    int   budget;

    // Expected parity values are worked out by hand. Even parity makes the total count of ones even; odd parity makes it odd.
    vecs[0] = '{0, 8'hA5, 1'b0, 40};
    vecs[1] = '{1, 8'h07, 1'b1, 44};
    vecs[2] = '{2, 8'h07, 1'b0, 44};
    vecs[3] = '{0, 8'h00, 1'b0, 40};
    vecs[4] = '{1, 8'h5A, 1'b0, 44};
    vecs[5] = '{2, 8'h5A, 1'b1, 44};
    vecs[6] = '{1, 8'h80, 1'b1, 44};
    vecs[7] = '{2, 8'hFF, 1'b1, 44};
    vecs[8] = '{0, 8'hFF, 1'b0, 40};
    vecs[9] = '{1, 8'h00, 1'b0, 44};

    reset = 1'b1;
    vld   = '0;
    dIn   = '0;

    $display("[TB] reset hold");
    repeat (5) begin
      @(posedge clock); #1;
      checkOutput("reset state dut0 {tx,ready,busy,done}", {tx[0], rdy[0], busy[0], done[0]}, 4'b1100);
    end
    checkOutput("reset state dut1/dut2 {tx,ready,busy,done}",
                {tx[1], rdy[1], busy[1], done[1], tx[2], rdy[2], busy[2], done[2]}, 8'b1100_1100);
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      base = doneCnt[vecs[i].dut];
      applyStimulus(vecs[i].dut, vecs[i].data, (vecs[i].dut != 0), vecs[i].expPar, vecs[i].expLen, 1'b1);
      target++;
      waitFrames(target);
      checkOutput($sformatf("vector %0d single done pulse", i), doneCnt[vecs[i].dut] - base, 1);
    end

    $display("[TB] back-to-back frames");
    base = doneCnt[0];
    waitReady(0);
    @(posedge clock); #1;
    dIn    = 8'h3C;
    vld[0] = 1'b1;
    expQ.push_back(makeExpect(0, 8'h3C, 1'b0, 1'b0, 40));
    @(posedge clock); #1;
    dIn = 8'hC3;
    expQ.push_back(makeExpect(0, 8'hC3, 1'b0, 1'b0, 40));
    budget = 0;
    do begin
      @(negedge clock);
      budget++;
    end while (rdy[0] !== 1'b1 && budget < 200);
    @(posedge clock); #1;
    vld[0] = 1'b0;
    target += 2;
    waitFrames(target);
    checkOutput("back-to-back idle gap cycles", lastGap[0], 1);
    checkOutput("back-to-back done pulses", doneCnt[0] - base, 2);

    $display("[TB] byte offered while busy");
    base = doneCnt[0];
    applyStimulus(0, 8'h00, 1'b0, 1'b0, 40, 1'b1);
    repeat (14) @(posedge clock);
    #1;
    dIn    = 8'hFF;
    vld[0] = 1'b1;
    @(negedge clock);
    checkOutput("ready low during busy pulse", rdy[0], 0);
    @(posedge clock); #1;
    vld[0] = 1'b0;
    target++;
    waitFrames(target);
    repeat (12) @(negedge clock);
    checkOutput("no frame started for ignored byte", {monActive[0], busy[0]}, 2'b00);
    checkOutput("frames after ignored byte", framesDone, target);
    checkOutput("done pulses after ignored byte", doneCnt[0] - base, 1);

    $display("[TB] reset during data bit 3");
    base = doneCnt[0];
    applyStimulus(0, 8'h96, 1'b0, 1'b0, 40, 1'b0);
    budget = 0;
    while (!(monActive[0] && monIdx[0] >= 16) && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("reached data bit 3", (monActive[0] && monIdx[0] >= 16), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("after abort {tx,ready,busy,done}", {tx[0], rdy[0], busy[0], done[0]}, 4'b1100);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    checkOutput("no done for aborted frame", doneCnt[0] - base, 0);
    checkOutput("no frame counted for aborted byte", framesDone, target);
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 40, 1'b1);
    target++;
    waitFrames(target);
    checkOutput("done after post-reset frame", doneCnt[0] - base, 1);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
